// File: rtl/adder_pipelined_if.sv
// adder_pipelined_if -- operand/result handshake bundle for adder_pipelined.
//   master : drives in_valid/in_a/in_b/in_ci/in_sub and out_ready,
//            observes in_ready and the result side.
//   slave  : the adder itself.
// Optional: out_ovf exists only when ADDER_PIPELINED_OVF_EN is defined.
interface adder_pipelined_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_ci;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
`ifdef ADDER_PIPELINED_OVF_EN
  logic             out_ovf;
`endif

  modport master (
    output in_valid, in_a, in_b, in_ci, in_sub, out_ready,
    input  in_ready, out_valid, out_result, out_carry
`ifdef ADDER_PIPELINED_OVF_EN
    , input out_ovf
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, in_ci, in_sub, out_ready,
    output in_ready, out_valid, out_result, out_carry
`ifdef ADDER_PIPELINED_OVF_EN
    , output out_ovf
`endif
  );
endinterface

// File: rtl/adder_pipelined.sv
// adder_pipelined -- carry-chunked pipelined adder/subtractor.
//   Each stage adds CHUNK bits; STAGES = WIDTH/CHUNK stages in total.
//   Operation: in_sub=0 -> A+B+ci, in_sub=1 -> A-B (carry out 1 = no borrow).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : adder_pipelined_if.slave (in_valid/in_ready/in_a/in_b/in_ci/in_sub,
//           out_valid/out_ready/out_result/out_carry[/out_ovf])
// Optional feature: define ADDER_PIPELINED_OVF_EN to add out_ovf (signed overflow).
module adder_pipelined #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  adder_pipelined_if.slave bus
);

  localparam int STAGES = WIDTH / CHUNK;

  if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : bad_cfg
    $error("adder_pipelined: WIDTH must be a positive multiple of CHUNK");
  end

  logic             en;
  logic             last_v;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Subtraction is A + ~B + 1, so the stage-0 carry is forced high.
  assign b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign c0    = bus.in_sub | bus.in_ci;

  // The whole pipeline advances together; it only freezes while a result
  // is waiting at the output and downstream is not taking it.
  assign en           = !last_v || bus.out_ready;
  assign bus.in_ready = en;

  // Operand registers shrink by CHUNK bits per stage (bits already added are
  // dropped and the next chunk is always at bit 0), while the result register
  // grows by CHUNK bits per stage.
  for (genvar s = 0; s < STAGES; s++) begin : st
    localparam int IW = WIDTH - s * CHUNK;
    localparam int RW = (s + 1) * CHUNK;

    logic [IW-1:0]  a_in;
    logic [IW-1:0]  b_in;
    logic           c_in;
    logic           v_in;
    logic [CHUNK:0] sum;
    logic [RW-1:0]  r_d;
    logic [RW-1:0]  r_q;
    logic           c_q;
    logic           v_q;

    if (s == 0) begin : src
      assign a_in = bus.in_a;
      assign b_in = b_eff;
      assign c_in = c0;
      assign v_in = bus.in_valid;
      assign r_d  = sum[CHUNK-1:0];
    end else begin : src
      assign a_in = st[s-1].fwd.a_q;
      assign b_in = st[s-1].fwd.b_q;
      assign c_in = st[s-1].c_q;
      assign v_in = st[s-1].v_q;
      assign r_d  = {sum[CHUNK-1:0], st[s-1].r_q};
    end

    assign sum = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + (CHUNK+1)'(c_in);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (en) begin
        r_q <= r_d;
        c_q <= sum[CHUNK];
        v_q <= v_in;
      end
    end

    if (s < STAGES - 1) begin : fwd
      logic [IW-CHUNK-1:0] a_q;
      logic [IW-CHUNK-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_in[IW-1:CHUNK];
          b_q <= b_in[IW-1:CHUNK];
        end
      end
    end
  end

  assign last_v         = st[STAGES-1].v_q;
  assign bus.out_valid  = last_v;
  assign bus.out_result = st[STAGES-1].r_q;
  assign bus.out_carry  = st[STAGES-1].c_q;

`ifdef ADDER_PIPELINED_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Carry into the MSB is recovered as a ^ b ^ sum at the MSB position,
  // then compared against the carry out of the MSB.
  assign ovf_d = st[STAGES-1].sum[CHUNK]
               ^ st[STAGES-1].a_in[CHUNK-1]
               ^ st[STAGES-1].b_in[CHUNK-1]
               ^ st[STAGES-1].sum[CHUNK-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_pipelined.sv
// tb_adder_pipelined -- directed and random checks of adder_pipelined
// at WIDTH/CHUNK = 16/4, 8/8 and 32/4.
module tb_adder_pipelined;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  adder_pipelined_if #(.WIDTH(16)) b16 ();
  adder_pipelined_if #(.WIDTH(8))  b8  ();
  adder_pipelined_if #(.WIDTH(32)) b32 ();

  adder_pipelined #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  adder_pipelined #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  adder_pipelined #(.WIDTH(32), .CHUNK(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));

  // Back-to-back stream: operands and hand-computed {carry, result}.
  localparam logic [15:0] SA  [6] = '{16'h0001, 16'h00FF, 16'hF000, 16'h1000, 16'hABCD, 16'h0000};
  localparam logic [15:0] SB  [6] = '{16'h0002, 16'h0001, 16'h1000, 16'h0001, 16'h1111, 16'h0001};
  localparam logic        SCI [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic        SSB [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [16:0] SE  [6] = '{17'h0_0003, 17'h0_0100, 17'h1_0000,
                                      17'h1_0FFF, 17'h0_BCDF, 17'h0_FFFF};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction on the 16-bit instance, checking latency too.
  task automatic one16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sub,
                       input logic [15:0] er, input logic ec, input logic eo);
    b16.in_a     = a;
    b16.in_b     = b;
    b16.in_ci    = ci;
    b16.in_sub   = sub;
    b16.in_valid = 1'b1;
    b16.out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, b16.in_ready, 1'b1);
    tick();                       // acceptance edge N
    b16.in_valid = 1'b0;
    tick();
    tick();                       // after N+2
    chk({tag, "_early"}, b16.out_valid, 1'b0);
    tick();                       // after N+3
    chk({tag, "_valid"},  b16.out_valid, 1'b1);
    chk({tag, "_result"}, b16.out_result, er);
    chk({tag, "_carry"},  b16.out_carry, ec);
`ifdef ADDER_PIPELINED_OVF_EN
    chk({tag, "_ovf"},    b16.out_ovf, eo);
`endif
    tick();
  endtask

  function automatic logic ovf_ref(input longint sa, input longint sb, input logic ci,
                                   input logic sub, input int w);
    longint r;
    longint hi;
    hi = (longint'(1) << (w - 1));
    r  = sub ? (sa - sb) : (sa + sb + longint'(ci));
    return (r >= hi) || (r < -hi);
  endfunction

  task automatic sweep8();
    logic [8:0] qe[$];
    logic       qo[$];
    int         qc[$];
    int         sent = 0;
    int         got  = 0;
    logic [7:0] a, b;
    logic       ci, sub;
    logic [8:0] e;
    b8.out_ready = 1'b1;
    for (int cyc = 0; cyc < 1010; cyc++) begin
      a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      b8.in_valid = (sent < 1000);
      b8.in_a = a; b8.in_b = b; b8.in_ci = ci; b8.in_sub = sub;
      #1;
      if (b8.out_valid) begin
        chk("sw8_nonempty", qe.size() != 0, 1'b1);
        if (qe.size() != 0) begin
          chk("sw8_result", {b8.out_carry, b8.out_result}, qe.pop_front());
          chk("sw8_latency", cyc - qc.pop_front(), 1);
`ifdef ADDER_PIPELINED_OVF_EN
          chk("sw8_ovf", b8.out_ovf, qo.pop_front());
`else
          void'(qo.pop_front());
`endif
        end
        got++;
      end
      if (b8.in_valid && b8.in_ready) begin
        if (sub) e = {a >= b, 8'(a - b)};
        else     e = {1'b0, a} + {1'b0, b} + 9'(ci);
        qe.push_back(e);
        qo.push_back(ovf_ref(longint'($signed(a)), longint'($signed(b)), ci, sub, 8));
        qc.push_back(cyc);
        sent++;
      end
      tick();
    end
    b8.in_valid = 1'b0;
    chk("sw8_count", got, 1000);
  endtask

  task automatic sweep32();
    logic [32:0] qe[$];
    logic        qo[$];
    int          qc[$];
    int          sent = 0;
    int          got  = 0;
    logic [31:0] a, b;
    logic        ci, sub;
    logic [32:0] e;
    b32.out_ready = 1'b1;
    for (int cyc = 0; cyc < 1020; cyc++) begin
      a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
      b32.in_valid = (sent < 1000);
      b32.in_a = a; b32.in_b = b; b32.in_ci = ci; b32.in_sub = sub;
      #1;
      if (b32.out_valid) begin
        chk("sw32_nonempty", qe.size() != 0, 1'b1);
        if (qe.size() != 0) begin
          chk("sw32_result", {b32.out_carry, b32.out_result}, qe.pop_front());
          chk("sw32_latency", cyc - qc.pop_front(), 8);
`ifdef ADDER_PIPELINED_OVF_EN
          chk("sw32_ovf", b32.out_ovf, qo.pop_front());
`else
          void'(qo.pop_front());
`endif
        end
        got++;
      end
      if (b32.in_valid && b32.in_ready) begin
        if (sub) e = {a >= b, 32'(a - b)};
        else     e = {1'b0, a} + {1'b0, b} + 33'(ci);
        qe.push_back(e);
        qo.push_back(ovf_ref(longint'($signed(a)), longint'($signed(b)), ci, sub, 32));
        qc.push_back(cyc);
        sent++;
      end
      tick();
    end
    b32.in_valid = 1'b0;
    chk("sw32_count", got, 1000);
  endtask

  initial begin
    logic [16:0] q[$];
    int          sent;
    int          got;

    b16.in_valid = 1'b0; b16.in_a = '0; b16.in_b = '0; b16.in_ci = 1'b0; b16.in_sub = 1'b0;
    b16.out_ready = 1'b0;
    b8.in_valid  = 1'b0; b8.in_a  = '0; b8.in_b  = '0; b8.in_ci  = 1'b0; b8.in_sub  = 1'b0;
    b8.out_ready = 1'b1;
    b32.in_valid = 1'b0; b32.in_a = '0; b32.in_b = '0; b32.in_ci = 1'b0; b32.in_sub = 1'b0;
    b32.out_ready = 1'b1;

    // Reset values (out_ready low: in_ready must still be 1 with nothing pending).
    rst_n = 1'b0;
    #12;
    chk("rst_out_valid",  b16.out_valid, 1'b0);
    chk("rst_out_result", b16.out_result, 16'h0000);
    chk("rst_out_carry",  b16.out_carry, 1'b0);
    chk("rst_in_ready",   b16.in_ready, 1'b1);
`ifdef ADDER_PIPELINED_OVF_EN
    chk("rst_out_ovf",    b16.out_ovf, 1'b0);
`endif
    chk("rst_valid8",  b8.out_valid, 1'b0);
    chk("rst_valid32", b32.out_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Directed single transactions.
    one16("add_basic",   16'h1234, 16'h0FF0, 1'b1, 1'b0, 16'h2225, 1'b0, 1'b0);
    one16("add_ripple",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    one16("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    one16("sub_borrow",  16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    one16("sub_ci_ign",  16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    one16("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    one16("add_all_one", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);

    // Back-to-back stream with a 4-cycle output stall.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      b16.out_ready = !(cyc >= 4 && cyc <= 7);
      b16.in_valid  = (sent < 6);
      if (sent < 6) begin
        b16.in_a = SA[sent]; b16.in_b = SB[sent]; b16.in_ci = SCI[sent]; b16.in_sub = SSB[sent];
      end
      #1;
      if (b16.out_valid && !b16.out_ready) chk("stall_in_ready", b16.in_ready, 1'b0);
      if (b16.out_valid) begin
        chk("stall_nonempty", q.size() != 0, 1'b1);
        if (q.size() != 0) chk("stall_result", {b16.out_carry, b16.out_result}, q[0]);
        if (b16.out_ready && q.size() != 0) begin
          void'(q.pop_front());
          got++;
        end
      end
      if (b16.in_valid && b16.in_ready) begin
        q.push_back(SE[sent]);
        sent++;
      end
      tick();
    end
    b16.in_valid = 1'b0;
    chk("stall_sent",  sent, 6);
    chk("stall_count", got, 6);

    // Reset while two transactions are in flight.
    b16.out_ready = 1'b1;
    b16.in_a = 16'h0101; b16.in_b = 16'h0202; b16.in_ci = 1'b0; b16.in_sub = 1'b0;
    b16.in_valid = 1'b1;
    tick();
    b16.in_a = 16'h1111; b16.in_b = 16'h2222;
    tick();
    b16.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid",  b16.out_valid, 1'b0);
    chk("midrst_result", b16.out_result, 16'h0000);
    tick();
    tick();
    chk("midrst_hold_valid", b16.out_valid, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_stale", b16.out_valid, 1'b0);
    end
    one16("post_reset", 16'h4321, 16'h1234, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    // Reset clears a held result without any clock edge.
    b16.out_ready = 1'b0;
    b16.in_a = 16'h0F0F; b16.in_b = 16'h0101; b16.in_ci = 1'b0; b16.in_sub = 1'b0;
    b16.in_valid = 1'b1;
    tick();
    b16.in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("held_valid",  b16.out_valid, 1'b1);
    chk("held_result", b16.out_result, 16'h1010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid",    b16.out_valid, 1'b0);
    chk("async_rst_result",   b16.out_result, 16'h0000);
    chk("async_rst_in_ready", b16.in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    b16.out_ready = 1'b1;
    tick();

    // Parameter sweep against a reference model.
    sweep8();
    sweep32();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_pipelined.md
ADDER_PIPELINED -- requirements
Module: adder_pipelined

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per pipeline stage; WIDTH SHALL be a multiple of CHUNK.
REQ-003 SHALL derive STAGES = WIDTH/CHUNK, default 4: number of pipeline stages.
REQ-004 SHALL use one clock and an asynchronous active-low reset, with the ports listed below.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  operands present.
REQ-008 in_ready  output  1  block accepts operands this cycle.
REQ-009 in_a  input  WIDTH  operand A.
REQ-010 in_b  input  WIDTH  operand B.
REQ-011 in_ci  input  1  carry in; ignored when in_sub=1.
REQ-012 in_sub  input  1  operation select: 0 = A+B+ci, 1 = A-B.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-016 out_carry  output  1  carry out of the MSB; for subtraction, 1 = no borrow.

Function
REQ-017 SHALL accept a transaction on a rising edge where in_valid=1 and in_ready=1.
REQ-018 SHALL compute per stage: stage s adds bits [s*CHUNK +: CHUNK] of A and B' plus the carry registered by stage s-1; stage 0 uses the carry input.
- B' = in_b when in_sub=0, ~in_b when in_sub=1.
- Stage 0 carry input = in_ci when in_sub=0, 1 when in_sub=1.
REQ-019 SHALL carry the not-yet-added upper operand bits and the completed lower result bits forward with each stage, along with a per-stage valid bit.
REQ-020 SHALL use a global advance enable: en = !out_valid || out_ready; all stage registers update only when en=1.
REQ-021 SHALL drive in_ready = en, combinationally.
REQ-022 SHALL set latency: a transaction accepted on edge N SHALL present out_valid=1 after edge N+STAGES-1 (3 edges after acceptance at defaults); with STAGES=1 it appears after edge N.
REQ-023 SHALL sustain throughput of one transaction per cycle while out_ready=1.
REQ-024 SHALL hold out_result, out_carry and out_valid stable while out_valid=1 and out_ready=0; no transaction is lost or duplicated.
REQ-025 SHALL propagate empty slots as bubbles: a cycle with en=1 and in_valid=0 loads stage 0 valid with 0.
REQ-026 SHALL keep transactions in acceptance order.

Reset
REQ-027 SHALL, on rst_n=0, immediately clear all stage valid bits, regardless of clk.
REQ-028 SHALL drive these reset values: out_valid=0, out_result=0, out_carry=0, and in_ready=1.
REQ-029 SHALL discard any transaction in flight when reset asserts mid-operation; after release, the first result is the first post-reset acceptance.

Configuration
REQ-030 SHALL, when macro ADDER_PIPELINED_OVF_EN is defined, add port out_ovf (output, 1 bit).
- out_ovf = two's-complement signed overflow of the operation: carry into MSB XOR carry out of MSB.
- out_ovf is registered alongside out_result, resets to 0, and obeys the same hold rule.
REQ-031 SHALL, when ADDER_PIPELINED_OVF_EN is undefined, omit port out_ovf and its logic; all other behaviour is identical.

Verification
REQ-032 SHALL cover basic add at defaults: A=0x1234, B=0x0FF0, ci=1, sub=0, out_ready=1 -> after 3 further edges, out_result=0x2225, out_carry=0.
REQ-033 SHALL cover carry ripple across all chunks: A=0xFFFF, B=0x0000, ci=1 -> out_result=0x0000, out_carry=1; out_ovf=0 when ADDER_PIPELINED_OVF_EN is defined.
REQ-034 SHALL cover subtract and overflow: A=0x8000, B=0x0001, sub=1 -> out_result=0x7FFF, out_carry=1, out_ovf=1; A=0x0003, B=0x0005, sub=1 -> 0xFFFE, out_carry=0.
REQ-035 SHALL cover back-to-back with stall: 6 consecutive transactions, out_ready held 0 for 4 cycles mid-stream.
- in_ready=0 while out_valid=1 during the stall.
- All 6 results appear in order, none lost or duplicated.
REQ-036 SHALL cover reset mid-flight: accept 2 transactions, assert rst_n=0 one cycle later.
- out_valid=0 immediately.
- After release, no stale result appears; the next accepted operand pair yields the correct result.
REQ-037 SHALL cover a parameter sweep: WIDTH=8 with CHUNK=8 (latency 0 extra edges) and WIDTH=32 with CHUNK=4 (7 extra edges), each against 1000 random operands compared to a reference A±B model.
